// File: rtl/fsbm_pkg.sv
// Shared constants and FSM state type for the full-search block-matching controller.
package fsbm_pkg;

    localparam int unsigned      SAD_W   = 12;
    localparam logic [SAD_W-1:0] SAD_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fsbm_state_e;

endpackage

// File: rtl/fsbm_tag_pipe.sv
// Valid + candidate-tag delay line; advances only on shift so tags stay aligned with the SAD datapath.
module fsbm_tag_pipe #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else if (shift) begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/fsbm_ctrl.sv
// Full-search motion-estimation controller: raster-issues candidates, tracks the minimum SAD.
// Optional macro FSBM_EARLY_EXIT_EN stops issuing once a zero SAD has been committed.
module fsbm_ctrl
    import fsbm_pkg::*;
#(
    parameter int unsigned SEARCH_W = 8,
    parameter int unsigned PE_LAT   = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        win_valid,
    input  logic [SAD_W-1:0]            pe_sum,
    output logic                        pe_enable,
    output logic [$clog2(SEARCH_W)-1:0] cand_x,
    output logic [$clog2(SEARCH_W)-1:0] cand_y,
    output logic                        busy,
    output logic                        done,
    output logic [SAD_W-1:0]            best_sad,
    output logic [$clog2(SEARCH_W)-1:0] best_x,
    output logic [$clog2(SEARCH_W)-1:0] best_y
);

    localparam int unsigned CW    = $clog2(SEARCH_W);
    localparam int unsigned TAG_W = 2 * CW;
    localparam int unsigned CNT_W = $clog2(PE_LAT + 1);
    localparam logic [CW-1:0] CMAX = CW'(SEARCH_W - 1);

    fsbm_state_e      state_q, state_d;
    logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]    bx_q, bx_d, by_q, by_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             issue, exit_now, cmp, better, last_x, last_y;
    logic             tag_valid;
    logic [TAG_W-1:0] tag_out;

`ifdef FSBM_EARLY_EXIT_EN
    assign exit_now = (best_sad_q == '0);
`else
    assign exit_now = 1'b0;
`endif

    assign pe_enable = (state_q == S_ISSUE) ? win_valid : (state_q == S_DRAIN);
    assign issue     = (state_q == S_ISSUE) && win_valid && !exit_now;
    assign cmp       = tag_valid && pe_enable;
    assign better    = cmp && (pe_sum < best_sad_q);
    assign last_x    = (cx_q == CMAX);
    assign last_y    = (cy_q == CMAX);

    fsbm_tag_pipe #(
        .DEPTH (PE_LAT),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .shift     (pe_enable),
        .in_valid  (issue),
        .in_tag    ({cy_q, cx_q}),
        .out_valid (tag_valid),
        .out_tag   (tag_out)
    );

    // cnt_q counts tags in flight so DRAIN can tell when the pipe is empty.
    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        bx_d       = bx_q;
        by_d       = by_q;
        best_sad_d = best_sad_q;
        cnt_d      = cnt_q + CNT_W'(issue) - CNT_W'(cmp);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    cx_d       = '0;
                    cy_d       = '0;
                    bx_d       = '0;
                    by_d       = '0;
                    best_sad_d = SAD_MAX;
                end
            end
            S_ISSUE: begin
                if (exit_now) begin
                    state_d = S_DRAIN;
                end else if (issue) begin
                    cx_d = last_x ? '0 : cx_q + CW'(1);
                    if (last_x) cy_d = cy_q + CW'(1);
                    if (last_x && last_y) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (better) begin
            best_sad_d = pe_sum;
            bx_d       = tag_out[CW-1:0];
            by_d       = tag_out[TAG_W-1:CW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            best_sad_q <= SAD_MAX;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            best_sad_q <= best_sad_d;
            cnt_q      <= cnt_d;
        end
    end

    assign cand_x   = cx_q;
    assign cand_y   = cy_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign best_sad = best_sad_q;
    assign best_x   = bx_q;
    assign best_y   = by_q;

endmodule

// File: doc/fsbm_ctrl.md
FSBM_CTRL -- requirements
Module: fsbm_ctrl

Interface
REQ-001 SHALL have parameter SEARCH_W, default 8: candidate positions per axis (x,y each 0..SEARCH_W-1), power of two, 2..64.
REQ-002 SHALL have parameter PE_LAT, default 5: SAD datapath cycles from enable-qualified input to valid sum.
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: pulse to begin one full search; ignored unless idle.
REQ-006 SHALL have port win_valid, input, 1: window memory presents pixels for the current cand_x/cand_y.
REQ-007 SHALL have port pe_sum, input, 12: SAD result from the datapath.
REQ-008 SHALL have port pe_enable, output, 1: datapath advance strobe.
REQ-009 SHALL have port cand_x and cand_y, output, log2(SEARCH_W) each: candidate offset being fetched.
REQ-010 SHALL have port busy, output, 1: search in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the result is final.
REQ-012 SHALL have port best_sad, output, 12: minimum SAD found.
REQ-013 SHALL have port best_x and best_y, output, log2(SEARCH_W) each: offset of best_sad.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-015 SHALL move IDLE->ISSUE on start; clear best_sad to 12'hFFF, best_x/best_y to 0, cand to (0,0).
REQ-016 SHALL drive pe_enable = win_valid in ISSUE, 1 in DRAIN, 0 in IDLE/DONE.
REQ-017 SHALL advance cand raster order (x fastest, wrap x to 0 and increment y) only on cycles with pe_enable=1 in ISSUE.
REQ-018 SHALL move ISSUE->DRAIN on the enabled cycle issuing (SEARCH_W-1,SEARCH_W-1).
REQ-019 SHALL carry a valid bit plus (x,y) tag through a PE_LAT-deep delay line that shifts only when pe_enable=1, so a tag pairs with its pe_sum exactly.
REQ-020 SHALL compare pe_sum against best_sad when the delay-line output is valid and pe_enable=1; update best on strict less-than only (earliest raster candidate wins ties).
REQ-021 SHALL stay in DRAIN until the delay line is empty, then go to DONE for one cycle (done=1), then IDLE.
REQ-022 SHALL hold best_sad/best_x/best_y stable from done until the next accepted start.
REQ-023 SHALL assert busy in ISSUE and DRAIN, and in DONE.
REQ-024 SHALL ignore start while busy; win_valid low in ISSUE freezes cand counters and delay line (stall, no loss).
REQ-025 SHALL total SEARCH_W^2 + PE_LAT + 1 cycles start-to-done with win_valid held high.

Reset
REQ-026 SHALL on rst force IDLE, pe_enable=0, busy=0, done=0, cand=(0,0), best_sad=12'hFFF, best_x=best_y=0, all delay-line valid bits 0.
REQ-027 SHALL on rst mid-search abandon the search with no done pulse.

Configuration
REQ-028 SHALL support macro FSBM_EARLY_EXIT_EN: when defined, a committed best_sad of 0 during ISSUE moves FSM to DRAIN immediately (remaining candidates not issued; in-flight tags still compared but cannot replace 0); when undefined, all SEARCH_W^2 candidates are always issued.

Structure
REQ-029 SHALL place SAD_W=12, SAD_MAX=12'hFFF, and the FSM state enum in package fsbm_pkg.
REQ-030 SHALL implement the tag delay line as sub-module fsbm_tag_pipe (parameters DEPTH, TAG_W; inputs shift, in_valid, in_tag; outputs out_valid, out_tag; async clear on rst).

Verification
REQ-031 SHALL check: SEARCH_W=4, pe_sum model with unique minimum 37 at (2,1), win_valid=1 -> done at cycle 16+5+1=22, best_sad=37, best=(2,1).
REQ-032 SHALL check: equal minimum 10 at (1,0) and (3,2) -> best=(1,0).
REQ-033 SHALL check: win_valid toggled 1,0 alternately -> identical result to case 1, pe_enable never high while win_valid low in ISSUE.
REQ-034 SHALL check: rst asserted at cycle 8 of a search -> all outputs at reset values next edge, no done; new start afterwards completes normally.
REQ-035 SHALL check: start pulsed during DRAIN -> ignored, single done.
REQ-036 SHALL check with FSBM_EARLY_EXIT_EN: SAD 0 at (1,0), SEARCH_W=4 -> done well before cycle 22, best_sad=0, best=(1,0); without macro done at 22.
